cp0_regfile: RTL and testbench

//  Coprocessor-0 register file, directly downstream of the exception/stall controller.
//  - Consumes that controller's commit strobe, exception type and exception PC.
//  - Handles MTC0/MFC0 accesses.
//  - Sources EBASE/STATUS/CAUSE/EPC back to the controller.
//  - Raises the interrupt request to the pipeline.

---
 rtl/cp0_pkg.sv | 43 ++++
 rtl/cp0_timer.sv | 57 +++++
 rtl/cp0_regfile.sv | 137 +++++++++++++
 tb/tb_cp0_regfile.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cp0_pkg.sv
// Shared constants and types for the coprocessor-0 register file: register numbers,
// exception codes, Status/Cause bit positions and MTC0 write masks.
package cp0_pkg;

  localparam logic [4:0] REG_COUNT   = 5'd9;
  localparam logic [4:0] REG_COMPARE = 5'd11;
  localparam logic [4:0] REG_STATUS  = 5'd12;
  localparam logic [4:0] REG_CAUSE   = 5'd13;
  localparam logic [4:0] REG_EPC     = 5'd14;
  localparam logic [4:0] REG_EBASE   = 5'd15;

  localparam logic [4:0] EXC_INT = 5'b00000;
  localparam logic [4:0] EXC_SYS = 5'b01000;

  localparam int STATUS_IE  = 0;
  localparam int STATUS_EXL = 1;
  localparam int CAUSE_BD   = 31;
  localparam int CAUSE_TI   = 30;
  localparam int IP_HI      = 15;
  localparam int IP_HW_LO   = 10;
  localparam int IP_SW_HI   = 9;
  localparam int IP_LO      = 8;
  localparam int IM_HI      = 15;
  localparam int IM_LO      = 8;
  localparam int EXC_HI     = 6;
  localparam int EXC_LO     = 2;

  localparam logic [31:0] STATUS_WMASK = 32'h0000_FF03;
  localparam logic [31:0] EBASE_WMASK  = 32'h3FFF_F000;

  typedef struct packed {
    logic syscall;
    logic eret;
    logic delay;
  } exc_type_t;

  function automatic logic [31:0] maskedWrite(input logic [31:0] oldVal,
                                              input logic [31:0] newVal,
                                              input logic [31:0] mask);
    return (oldVal & ~mask) | (newVal & mask);
  endfunction

endpackage

// File: rtl/cp0_timer.sv
// Count/Compare timer for CP0: prescaled Count, Compare register and the timer
// interrupt flag TI. Only instantiated when CP0_TIMER_EN is defined.
module cp0_timer #(
  parameter int COUNT_DIV = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_countWe,
  input  logic        i_compareWe,
  input  logic        i_clrTi,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_count,
  output logic [31:0] o_compare,
  output logic        o_ti
);

  localparam int PW = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;

  logic [PW-1:0] r_pre;
  logic [31:0]   r_count;
  logic [31:0]   r_compare;
  logic          r_ti;
  logic          w_wrap;
  logic [31:0]   w_countInc;

  assign w_wrap     = (r_pre == PW'(COUNT_DIV - 1));
  assign w_countInc = r_count + 32'd1;

  // A software write to Count replaces the increment and restarts the prescaler;
  // the match always compares against the Compare value held before this edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pre     <= '0;
      r_count   <= '0;
      r_compare <= '0;
      r_ti      <= 1'b0;
    end else begin
      if (i_countWe) begin
        r_count <= i_wdata;
        r_pre   <= '0;
      end else begin
        r_pre <= w_wrap ? '0 : r_pre + 1'b1;
        if (w_wrap) r_count <= w_countInc;
      end
      if (i_compareWe) r_compare <= i_wdata;
      if (i_clrTi)
        r_ti <= 1'b0;
      else if (!i_countWe && w_wrap && (w_countInc == r_compare))
        r_ti <= 1'b1;
    end
  end

  assign o_count   = r_count;
  assign o_compare = r_compare;
  assign o_ti      = r_ti;

endmodule

// File: rtl/cp0_regfile.sv
// Coprocessor-0 register file: exception commit, MTC0/MFC0 access and interrupt request.
// Optional Count/Compare timer is compiled in with the macro CP0_TIMER_EN.
module cp0_regfile
  import cp0_pkg::*;
#(
  parameter logic [31:0] EBASE_RESET = 32'h8000_1000,
  parameter int          COUNT_DIV   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        CP0WE,
  input  logic [2:0]  ExcepType,
  input  logic [31:0] ExcPC,
  input  logic        MtcWE,
  input  logic [4:0]  MtcAddr,
  input  logic [31:0] MtcData,
  input  logic [4:0]  MfcAddr,
  input  logic [5:0]  HwInt,
  output logic [31:0] MfcData,
  output logic [31:0] CP0EBASE,
  output logic [31:0] CP0STATUS,
  output logic [31:0] CP0CAUSE,
  output logic [31:0] CP0EPC,
  output logic        IntReq
);

  exc_type_t   w_exc;
  logic        w_syscall;
  logic        w_eret;
  logic        w_mtcStatus;
  logic        w_mtcCause;
  logic        w_mtcEpc;
  logic        w_mtcEbase;
  logic [31:0] w_count;
  logic [31:0] w_compare;
  logic        w_ti;
  logic [5:0]  w_hwSample;
  logic [31:0] w_cause;

  logic [31:0] r_status;
  logic [31:0] r_epc;
  logic [31:0] r_ebase;
  logic        r_causeBd;
  logic [5:0]  r_causeHw;
  logic [1:0]  r_causeSw;
  logic [4:0]  r_excCode;

  assign w_exc     = exc_type_t'(ExcepType);
  assign w_syscall = CP0WE & w_exc.syscall;
  assign w_eret    = CP0WE & w_exc.eret & ~w_exc.syscall;

  // A commit owns every register it touches for that cycle, so MTC0 to those is dropped.
  assign w_mtcStatus = MtcWE && (MtcAddr == REG_STATUS) && !w_syscall && !w_eret;
  assign w_mtcCause  = MtcWE && (MtcAddr == REG_CAUSE) && !w_syscall;
  assign w_mtcEpc    = MtcWE && (MtcAddr == REG_EPC) && !w_syscall;
  assign w_mtcEbase  = MtcWE && (MtcAddr == REG_EBASE);

`ifdef CP0_TIMER_EN
  cp0_timer #(
    .COUNT_DIV (COUNT_DIV)
  ) u_timer (
    .clk         (clk),
    .rst_n       (rst),
    .i_countWe   (MtcWE && (MtcAddr == REG_COUNT)),
    .i_compareWe (MtcWE && (MtcAddr == REG_COMPARE)),
    .i_clrTi     (MtcWE && (MtcAddr == REG_COMPARE)),
    .i_wdata     (MtcData),
    .o_count     (w_count),
    .o_compare   (w_compare),
    .o_ti        (w_ti)
  );
  assign w_hwSample = {HwInt[5] | w_ti, HwInt[4:0]};
`else
  localparam int unusedCountDiv = COUNT_DIV;
  assign w_count    = '0;
  assign w_compare  = '0;
  assign w_ti       = 1'b0;
  assign w_hwSample = HwInt;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_status  <= '0;
      r_epc     <= '0;
      r_ebase   <= EBASE_RESET;
      r_causeBd <= 1'b0;
      r_causeHw <= '0;
      r_causeSw <= '0;
      r_excCode <= EXC_INT;
    end else begin
      r_causeHw <= w_hwSample;
      if (w_syscall) begin
        r_epc                <= ExcPC;
        r_causeBd            <= w_exc.delay;
        r_excCode            <= EXC_SYS;
        r_status[STATUS_EXL] <= 1'b1;
      end else if (w_eret) begin
        r_status[STATUS_EXL] <= 1'b0;
      end
      if (w_mtcStatus) r_status  <= maskedWrite(r_status, MtcData, STATUS_WMASK);
      if (w_mtcCause)  r_causeSw <= MtcData[IP_SW_HI:IP_LO];
      if (w_mtcEpc)    r_epc     <= MtcData;
      if (w_mtcEbase)  r_ebase   <= maskedWrite(r_ebase, MtcData, EBASE_WMASK);
    end
  end

  always_comb begin
    w_cause                    = '0;
    w_cause[CAUSE_BD]          = r_causeBd;
    w_cause[CAUSE_TI]          = w_ti;
    w_cause[IP_HI:IP_HW_LO]    = r_causeHw;
    w_cause[IP_SW_HI:IP_LO]    = r_causeSw;
    w_cause[EXC_HI:EXC_LO]     = r_excCode;
  end

  // MFC0 sees only registered state; a same-cycle MTC0 is not forwarded.
  always_comb begin
    MfcData = '0;
    case (MfcAddr)
      REG_COUNT:   MfcData = w_count;
      REG_COMPARE: MfcData = w_compare;
      REG_STATUS:  MfcData = r_status;
      REG_CAUSE:   MfcData = w_cause;
      REG_EPC:     MfcData = r_epc;
      REG_EBASE:   MfcData = r_ebase;
      default:     MfcData = '0;
    endcase
  end

  assign CP0EBASE  = r_ebase;
  assign CP0STATUS = r_status;
  assign CP0CAUSE  = w_cause;
  assign CP0EPC    = r_epc;
  assign IntReq    = r_status[STATUS_IE] & ~r_status[STATUS_EXL] &
                     (|(w_cause[IP_HI:IP_LO] & r_status[IM_HI:IM_LO]));

endmodule

// File: tb/tb_cp0_regfile.sv
// Randomized scoreboard bench for cp0_regfile against a behavioural CP0 model.
// Timer checks are active when CP0_TIMER_EN is defined.
module tb_cp0_regfile;

  localparam int COUNT_DIV = 2;

  logic        clk;
  logic        rst;
  logic        CP0WE;
  logic [2:0]  ExcepType;
  logic [31:0] ExcPC;
  logic        MtcWE;
  logic [4:0]  MtcAddr;
  logic [31:0] MtcData;
  logic [4:0]  MfcAddr;
  logic [5:0]  HwInt;
  logic [31:0] MfcData;
  logic [31:0] CP0EBASE;
  logic [31:0] CP0STATUS;
  logic [31:0] CP0CAUSE;
  logic [31:0] CP0EPC;
  logic        IntReq;

  cp0_regfile #(
    .EBASE_RESET (32'h8000_1000),
    .COUNT_DIV   (COUNT_DIV)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .CP0WE     (CP0WE),
    .ExcepType (ExcepType),
    .ExcPC     (ExcPC),
    .MtcWE     (MtcWE),
    .MtcAddr   (MtcAddr),
    .MtcData   (MtcData),
    .MfcAddr   (MfcAddr),
    .HwInt     (HwInt),
    .MfcData   (MfcData),
    .CP0EBASE  (CP0EBASE),
    .CP0STATUS (CP0STATUS),
    .CP0CAUSE  (CP0CAUSE),
    .CP0EPC    (CP0EPC),
    .IntReq    (IntReq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] ebase;
    logic [31:0] status;
    logic [31:0] cause;
    logic [31:0] epc;
    logic [31:0] mfc;
    logic        intReq;
  } expect_t;

  expect_t expQ[$];
  expect_t monE;
  int checks = 0;
  int errors = 0;

  // Reference model state, kept as architectural fields
  logic [31:0] mStatus, mEpc, mEbase, mCount, mCompare;
  logic        mBd, mTi;
  logic [5:0]  mHw;
  logic [1:0]  mSw;
  logic [4:0]  mExc;
  int          mTicks;

  task automatic modelReset();
    mStatus = 0; mEpc = 0; mEbase = 32'h8000_1000; mCount = 0; mCompare = 0;
    mBd = 0; mTi = 0; mHw = 0; mSw = 0; mExc = 0; mTicks = 0;
  endtask

  function automatic logic [31:0] modelCause();
    return {mBd, mTi, 14'd0, mHw, mSw, 1'b0, mExc, 2'b00};
  endfunction

  function automatic logic modelIntReq();
    logic [31:0] c;
    c = modelCause();
    return mStatus[0] && !mStatus[1] && ((c[15:8] & mStatus[15:8]) != 8'd0);
  endfunction

  function automatic logic [31:0] modelRead(input logic [4:0] a);
    case (a)
      5'd9:    return mCount;
      5'd11:   return mCompare;
      5'd12:   return mStatus;
      5'd13:   return modelCause();
      5'd14:   return mEpc;
      5'd15:   return mEbase;
      default: return 32'd0;
    endcase
  endfunction

  task automatic modelStep(input logic we, input logic [2:0] typ, input logic [31:0] pc,
                           input logic mwe, input logic [4:0] maddr, input logic [31:0] mdata,
                           input logic [5:0] hw);
    logic sys, er, tiOld;
    sys   = we && typ[2];
    er    = we && typ[1] && !typ[2];
    tiOld = mTi;
`ifdef CP0_TIMER_EN
    if (mwe && maddr == 5'd9) begin
      mCount = mdata;
      mTicks = 0;
    end else begin
      mTicks++;
      if (mTicks == COUNT_DIV) begin
        mTicks = 0;
        mCount = mCount + 32'd1;
        if (mCount == mCompare) mTi = 1'b1;
      end
    end
    if (mwe && maddr == 5'd11) begin
      mCompare = mdata;
      mTi = 1'b0;
    end
    mHw = {hw[5] | tiOld, hw[4:0]};
`else
    mHw = hw;
`endif
    if (sys) begin
      mEpc = pc; mBd = typ[0]; mExc = 5'b01000; mStatus[1] = 1'b1;
    end else if (er) begin
      mStatus[1] = 1'b0;
    end
    if (mwe) begin
      case (maddr)
        5'd12: if (!sys && !er) mStatus = (mStatus & ~32'h0000_FF03) | (mdata & 32'h0000_FF03);
        5'd13: if (!sys) mSw = mdata[9:8];
        5'd14: if (!sys) mEpc = mdata;
        5'd15: mEbase = (mEbase & ~32'h3FFF_F000) | (mdata & 32'h3FFF_F000);
        default: ;
      endcase
    end
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compares the DUT against whatever the stimulus side predicted for this cycle
  always @(negedge clk) begin
    while (expQ.size() > 0) begin
      monE = expQ.pop_front();
      checkOutput("sbEbase",  CP0EBASE,  monE.ebase);
      checkOutput("sbStatus", CP0STATUS, monE.status);
      checkOutput("sbCause",  CP0CAUSE,  monE.cause);
      checkOutput("sbEpc",    CP0EPC,    monE.epc);
      checkOutput("sbMfc",    MfcData,   monE.mfc);
      checkOutput("sbIntReq", {31'd0, IntReq}, {31'd0, monE.intReq});
    end
  end

  // Entered and left at posedge+1; predicts this cycle's outputs, then advances the model
  task automatic applyStimulus(input logic we, input logic [2:0] typ, input logic [31:0] pc,
                               input logic mwe, input logic [4:0] maddr, input logic [31:0] mdata,
                               input logic [4:0] mfa, input logic [5:0] hw);
    expect_t e;
    CP0WE = we; ExcepType = typ; ExcPC = pc;
    MtcWE = mwe; MtcAddr = maddr; MtcData = mdata; MfcAddr = mfa; HwInt = hw;
    e.ebase  = mEbase;
    e.status = mStatus;
    e.cause  = modelCause();
    e.epc    = mEpc;
    e.mfc    = modelRead(mfa);
    e.intReq = modelIntReq();
    expQ.push_back(e);
    modelStep(we, typ, pc, mwe, maddr, mdata, hw);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input logic [4:0] mfa, input logic [5:0] hw);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 3'b000, 32'd0, 1'b0, 5'd0, 32'd0, mfa, hw);
  endtask

  task automatic randomCycles(input int n);
    logic [4:0] addrs [6];
    logic [4:0] a;
    addrs = '{5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15};
    for (int i = 0; i < n; i++) begin
      a = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : addrs[$urandom_range(0, 5)];
      applyStimulus($urandom_range(0, 3) == 0, 3'($urandom_range(0, 7)), $urandom,
                    1'($urandom_range(0, 1)), a, $urandom,
                    5'($urandom_range(0, 16)), 6'($urandom_range(0, 63)));
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired actual=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b0; CP0WE = 0; ExcepType = 0; ExcPC = 0;
    MtcWE = 0; MtcAddr = 0; MtcData = 0; MfcAddr = 5'd15; HwInt = 0;
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rstEbase",  CP0EBASE, 32'h8000_1000);
    checkOutput("rstStatus", CP0STATUS, 32'd0);
    checkOutput("rstMfcEbase", MfcData, 32'h8000_1000);
    rst = 1'b1;

    // Syscall in a delay slot, then Eret
    applyStimulus(1'b1, 3'b101, 32'h8000_0040, 1'b0, 5'd0, 32'd0, 5'd13, 6'd0);
    checkOutput("sysEpc",  CP0EPC, 32'h8000_0040);
    checkOutput("sysBd",   {31'd0, CP0CAUSE[31]}, 32'd1);
    checkOutput("sysCode", {27'd0, CP0CAUSE[6:2]}, 32'd8);
    checkOutput("sysExl",  {31'd0, CP0STATUS[1]}, 32'd1);
    applyStimulus(1'b1, 3'b010, 32'd0, 1'b0, 5'd0, 32'd0, 5'd12, 6'd0);
    checkOutput("eretExl", {31'd0, CP0STATUS[1]}, 32'd0);

    // Commit beats MTC0 on EPC
    applyStimulus(1'b1, 3'b100, 32'hBFC0_0000, 1'b1, 5'd14, 32'h1234_5678, 5'd14, 6'd0);
    checkOutput("conflictEpc", CP0EPC, 32'hBFC0_0000);

    // Write masks
    applyStimulus(1'b0, 3'b000, 32'd0, 1'b1, 5'd12, 32'hFFFF_FFFF, 5'd12, 6'd0);
    checkOutput("maskStatus", MfcData, 32'h0000_FF03);
    applyStimulus(1'b0, 3'b000, 32'd0, 1'b1, 5'd13, 32'hFFFF_FFFF, 5'd13, 6'd0);
    checkOutput("maskCauseSw",   {30'd0, CP0CAUSE[9:8]}, 32'd3);
    checkOutput("maskCauseCode", {27'd0, CP0CAUSE[6:2]}, 32'd8);
    applyStimulus(1'b0, 3'b000, 32'd0, 1'b1, 5'd15, 32'hFFFF_FFFF, 5'd15, 6'd0);
    checkOutput("maskEbase", CP0EBASE, 32'hBFFF_F000);

    // Interrupt request
    applyStimulus(1'b0, 3'b000, 32'd0, 1'b1, 5'd12, 32'h0000_0401, 5'd12, 6'b000001);
    checkOutput("intReqOn", {31'd0, IntReq}, 32'd1);
    applyStimulus(1'b0, 3'b000, 32'd0, 1'b1, 5'd12, 32'h0000_0403, 5'd12, 6'b000001);
    checkOutput("intReqExl", {31'd0, IntReq}, 32'd0);
    idle(2, 5'd13, 6'd0);

`ifdef CP0_TIMER_EN
    applyStimulus(1'b0, 3'b000, 32'd0, 1'b1, 5'd11, 32'd5, 5'd9, 6'd0);
    applyStimulus(1'b0, 3'b000, 32'd0, 1'b1, 5'd9, 32'd0, 5'd9, 6'd0);
    idle(9, 5'd9, 6'd0);
    checkOutput("tiEarly", {31'd0, CP0CAUSE[30]}, 32'd0);
    idle(1, 5'd9, 6'd0);
    checkOutput("tiSet", {31'd0, CP0CAUSE[30]}, 32'd1);
    applyStimulus(1'b0, 3'b000, 32'd0, 1'b1, 5'd11, 32'd100, 5'd9, 6'd0);
    checkOutput("tiClear", {31'd0, CP0CAUSE[30]}, 32'd0);
    applyStimulus(1'b0, 3'b000, 32'd0, 1'b1, 5'd9, 32'hFFFF_FFFF, 5'd9, 6'd0);
    checkOutput("countMax", MfcData, 32'hFFFF_FFFF);
    idle(2, 5'd9, 6'd0);
    checkOutput("countWrap", MfcData, 32'd0);
`else
    applyStimulus(1'b0, 3'b000, 32'd0, 1'b1, 5'd9, 32'h0000_0055, 5'd9, 6'd0);
    checkOutput("noTimerCount", MfcData, 32'd0);
`endif

    randomCycles(400);

    // Asynchronous reset in the middle of a clock phase
    MfcAddr = 5'd12;
    #2;
    rst = 1'b0;
    #1;
    checkOutput("midRstEbase",  CP0EBASE, 32'h8000_1000);
    checkOutput("midRstStatus", CP0STATUS, 32'd0);
    checkOutput("midRstCause",  CP0CAUSE, 32'd0);
    checkOutput("midRstEpc",    CP0EPC, 32'd0);
    checkOutput("midRstMfc",    MfcData, 32'd0);
    checkOutput("midRstIntReq", {31'd0, IntReq}, 32'd0);
    modelReset();
    @(posedge clk);
    #1;
    rst = 1'b1;

    randomCycles(200);
    @(negedge clk);
    #1;
    checkOutput("queueDrained", 32'(expQ.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
